// File: rtl/nt_pkg.sv
// Shared definitions for the per-transmitter level integrators and the
// 10-bit neurotransmitter_level bus they feed.
package nt_pkg;

    localparam int NT_LEVEL_W = 2;
    localparam int NT_BUS_W   = 10;

    typedef enum logic [NT_LEVEL_W-1:0] {
        LOW     = 2'd0,
        NORMAL  = 2'd1,
        HIGH    = 2'd2,
        EXTREME = 2'd3
    } nt_level_e;

    // LSB position of each transmitter's 2-bit slice in the bus
    localparam int NT_CORT_LSB = 0;
    localparam int NT_DOP_LSB  = 2;
    localparam int NT_GABA_LSB = 4;
    localparam int NT_NE_LSB   = 6;
    localparam int NT_SER_LSB  = 8;

endpackage

// File: rtl/nt_level_quantizer.sv
// Hysteresis quantiser: maps the registered integrator value onto a 2-bit
// level, moving at most one level per enabled clock.
module nt_level_quantizer
    import nt_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HYST        = 4,
    parameter int RESET_LEVEL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [WIDTH-1:0]      value,
    output logic [NT_LEVEL_W-1:0] level,
    output logic                  changed
);

    localparam int Q = 1 << (WIDTH - 2);

    logic [NT_LEVEL_W-1:0] level_q, level_d;
    logic                  changed_q, changed_d;
    logic [WIDTH+1:0]      val_ext, up_thr, dn_thr;

    always_comb begin
        level_d   = level_q;
        changed_d = 1'b0;
        val_ext   = (WIDTH+2)'(value);
        up_thr    = (WIDTH+2)'((int'(level_q) + 1) * Q + HYST);
        dn_thr    = (WIDTH+2)'(int'(level_q) * Q);
        if (ena) begin
            if (level_q != EXTREME && val_ext >= up_thr) begin
                level_d   = level_q + 1'b1;
                changed_d = 1'b1;
            end else if (level_q != LOW && (val_ext + (WIDTH+2)'(HYST)) < dn_thr) begin
                level_d   = level_q - 1'b1;
                changed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= NT_LEVEL_W'(RESET_LEVEL);
            changed_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            changed_q <= changed_d;
        end
    end

    assign level   = level_q;
    assign changed = changed_q;

endmodule

// File: rtl/neurotransmitter_level_integrator.sv
// Saturating, leaky integrator of regulator inc/dec requests, updated on a
// prescaled tick, with a hysteresis-quantised 2-bit level output.
module neurotransmitter_level_integrator
    import nt_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE   = 16,
    parameter int STEP_SLOW  = 1,
    parameter int STEP_FAST  = 8,
    parameter int BASELINE   = 64,
    parameter int IDLE_TICKS = 8,
    parameter int HYST       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  fast,
    output logic [NT_LEVEL_W-1:0] level,
    output logic [WIDTH-1:0]      value,
    output logic                  sat_hi,
    output logic                  sat_lo,
    output logic                  changed
);

    localparam int CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
    localparam logic [WIDTH:0]   MAX_V  = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0] BASE_V = WIDTH'(BASELINE);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WIDTH-1:0]  value_q, value_d;
    logic [WIDTH:0]    val_ext, step_ext, sum, diff;
    logic              tick;

    always_comb begin
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        value_d  = value_q;
        tick     = ena && (cnt_q == CNT_W'(PRESCALE - 1));
        val_ext  = {1'b0, value_q};
        step_ext = fast ? (WIDTH+1)'(STEP_FAST) : (WIDTH+1)'(STEP_SLOW);
        sum      = val_ext + step_ext;
        diff     = val_ext - step_ext;

        if (ena) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        if (tick) begin
            if (inc && !dec) begin
                value_d = (sum > MAX_V) ? MAX_V[WIDTH-1:0] : sum[WIDTH-1:0];
                idle_d  = '0;
            end else if (dec && !inc) begin
                value_d = (val_ext < step_ext) ? '0 : diff[WIDTH-1:0];
                idle_d  = '0;
            end else if (inc && dec) begin
                idle_d = '0;
            end else if (idle_q == IDLE_W'(IDLE_TICKS - 1)) begin
                // idle run complete: one LSB toward baseline, fast ignored
                idle_d = '0;
                if (value_q > BASE_V) begin
                    value_d = value_q - 1'b1;
                end else if (value_q < BASE_V) begin
                    value_d = value_q + 1'b1;
                end
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idle_q  <= '0;
            value_q <= BASE_V;
        end else begin
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            value_q <= value_d;
        end
    end

    nt_level_quantizer #(
        .WIDTH       (WIDTH),
        .HYST        (HYST),
        .RESET_LEVEL (BASELINE >> (WIDTH - 2))
    ) u_quantizer (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .value   (value_q),
        .level   (level),
        .changed (changed)
    );

    assign value  = value_q;
    assign sat_hi = (value_q == '1);
    assign sat_lo = (value_q == '0);

endmodule

// File: tb/tb_neurotransmitter_level_integrator.sv
// Randomised and directed bench for neurotransmitter_level_integrator with a
// cycle-level arithmetic reference model.
module tb_neurotransmitter_level_integrator;

    localparam int W    = 8;
    localparam int P    = 4;
    localparam int SS   = 1;
    localparam int SF   = 8;
    localparam int BASE = 64;
    localparam int IDLE = 3;
    localparam int HY   = 4;
    localparam int QS   = 64;
    localparam int VMAX = 255;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0, inc = 1'b0, dec = 1'b0, fast = 1'b0;
    logic [1:0]   level;
    logic [W-1:0] value;
    logic         sat_hi, sat_lo, changed;

    int checks = 0;
    int errors = 0;

    int m_val, m_lvl, m_chg, m_cnt, m_idle;

    neurotransmitter_level_integrator #(
        .WIDTH      (W),
        .PRESCALE   (P),
        .STEP_SLOW  (SS),
        .STEP_FAST  (SF),
        .BASELINE   (BASE),
        .IDLE_TICKS (IDLE),
        .HYST       (HY)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .inc     (inc),
        .dec     (dec),
        .fast    (fast),
        .level   (level),
        .value   (value),
        .sat_hi  (sat_hi),
        .sat_lo  (sat_lo),
        .changed (changed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic i, input logic d, input logic f);
        ena = e; inc = i; dec = d; fast = f;
    endtask

    // Reference: value changes only on ticks, level chases value one clock behind
    always @(posedge clk or negedge rst_n) begin : model
        int nv, nl, ni;
        if (!rst_n) begin
            m_val <= BASE; m_lvl <= BASE / QS; m_chg <= 0; m_cnt <= 0; m_idle <= 0;
        end else if (ena) begin
            nv = m_val; nl = m_lvl; ni = m_idle;
            if (m_lvl < 3 && m_val >= (m_lvl + 1) * QS + HY) nl = m_lvl + 1;
            else if (m_lvl > 0 && m_val + HY < m_lvl * QS) nl = m_lvl - 1;
            if (m_cnt == P - 1) begin
                if (inc && !dec) begin
                    nv = m_val + (fast ? SF : SS);
                    if (nv > VMAX) nv = VMAX;
                    ni = 0;
                end else if (dec && !inc) begin
                    nv = m_val - (fast ? SF : SS);
                    if (nv < 0) nv = 0;
                    ni = 0;
                end else if (inc && dec) begin
                    ni = 0;
                end else begin
                    ni = m_idle + 1;
                    if (ni == IDLE) begin
                        ni = 0;
                        if (nv > BASE) nv = nv - 1;
                        else if (nv < BASE) nv = nv + 1;
                    end
                end
            end
            m_val  <= nv;
            m_lvl  <= nl;
            m_chg  <= (nl != m_lvl) ? 1 : 0;
            m_idle <= ni;
            m_cnt  <= (m_cnt + 1) % P;
        end else begin
            m_chg <= 0;
        end
    end

    always @(negedge clk) begin
        check("value", 32'(value), 32'(m_val));
        check("level", 32'(level), 32'(m_lvl));
        check("changed", 32'(changed), 32'(m_chg));
        check("sat_hi", 32'(sat_hi), (m_val == VMAX) ? 32'd1 : 32'd0);
        check("sat_lo", 32'(sat_lo), (m_val == 0) ? 32'd1 : 32'd0);
    end

    initial begin
        int mode;
        int r;
        step(3);
        check("rst_value", 32'(value), 32'd64);
        check("rst_level", 32'(level), 32'd1);
        check("rst_changed", 32'(changed), 32'd0);
        rst_n = 1'b1;

        // fast rise: 128 sits below the 132 threshold, 136 crosses it
        drive(1, 1, 0, 1);
        step(32);
        check("rise_128", 32'(value), 32'd128);
        check("rise_128_lvl", 32'(level), 32'd1);
        step(4);
        check("rise_136", 32'(value), 32'd136);
        check("rise_136_lvl", 32'(level), 32'd1);
        drive(1, 0, 1, 0);
        step(1);
        check("rise_lvl2", 32'(level), 32'd2);
        check("rise_chg", 32'(changed), 32'd1);

        // slow fall: 124 holds level 2, 123 drops it
        step(47);
        check("fall_124", 32'(value), 32'd124);
        check("fall_124_lvl", 32'(level), 32'd2);
        step(4);
        check("fall_123", 32'(value), 32'd123);
        step(1);
        check("fall_lvl1", 32'(level), 32'd1);
        check("fall_chg", 32'(changed), 32'd1);

        drive(1, 1, 0, 1);
        step(79);
        check("sat_hi_val", 32'(value), 32'd255);
        check("sat_hi_flag", 32'(sat_hi), 32'd1);
        drive(1, 0, 1, 1);
        step(160);
        check("sat_lo_val", 32'(value), 32'd0);
        check("sat_lo_flag", 32'(sat_lo), 32'd1);

        // leak toward baseline from both sides
        drive(1, 1, 0, 1);
        step(32);
        drive(1, 1, 0, 0);
        step(24);
        check("leak_start", 32'(value), 32'd70);
        drive(1, 0, 0, 1);
        step(12);
        check("leak_69", 32'(value), 32'd69);
        step(60);
        check("leak_64", 32'(value), 32'd64);
        step(40);
        check("leak_hold", 32'(value), 32'd64);
        drive(1, 0, 1, 0);
        step(16);
        check("leak_60", 32'(value), 32'd60);
        drive(1, 0, 0, 0);
        step(48);
        check("leak_up_64", 32'(value), 32'd64);

        // conflict clears the idle run
        drive(1, 0, 1, 0);
        step(24);
        drive(1, 0, 0, 0);
        step(8);
        check("idle2", 32'(value), 32'd58);
        drive(1, 1, 1, 1);
        step(4);
        check("conflict", 32'(value), 32'd58);
        drive(1, 0, 0, 0);
        step(8);
        check("conflict_idle2", 32'(value), 32'd58);
        step(4);
        check("conflict_leak", 32'(value), 32'd59);

        // freeze with prescaler parked at 2
        step(2);
        drive(0, 1, 0, 1);
        step(20);
        check("freeze_val", 32'(value), 32'd59);
        check("freeze_lvl", 32'(level), 32'd0);
        check("freeze_chg", 32'(changed), 32'd0);
        ena = 1'b1;
        step(1);
        check("resume_notick", 32'(value), 32'd59);
        step(1);
        check("resume_tick", 32'(value), 32'd67);

        // asynchronous reset in mid-cycle
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_value", 32'(value), 32'd64);
        check("async_level", 32'(level), 32'd1);
        check("async_chg", 32'(changed), 32'd0);
        check("async_sat", {30'd0, sat_hi, sat_lo}, 32'd0);
        step(1);
        rst_n = 1'b1;

        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) mode = int'($urandom_range(0, 3));
            r = int'($urandom);
            ena  = (r % 10) != 0;
            fast = r[4];
            case (mode)
                0: begin inc = r[5]; dec = r[6]; end
                1: begin inc = (r[9:7] != 0); dec = (r[12:10] == 0); end
                2: begin dec = (r[9:7] != 0); inc = (r[12:10] == 0); end
                default: begin inc = (r[15:13] == 0); dec = 1'b0; end
            endcase
            if ((r >> 20) % 700 == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            step(1);
        end
        rst_n = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
